// File: rtl/package_settings.sv
// rtl/package_settings.sv - shared sample width, delay-line defaults and types
package package_settings;

   localparam int SIZE_DATA            = 16;
   localparam int MAX_DELAY_DEFAULT    = 16;
   localparam int NUM_CHANNELS_DEFAULT = 4;

   typedef enum logic {FILL, RUN} delay_state_t;

   typedef logic signed [SIZE_DATA-1:0] sample_t;

endpackage

// File: rtl/delay_line_buffer.sv
// rtl/delay_line_buffer.sv - single-channel circular buffer with registered read-before-write output
module delay_line_buffer
   import package_settings::*;
#(
   parameter int DATA_WIDTH = SIZE_DATA,
   parameter int DEPTH      = MAX_DELAY_DEFAULT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [$clog2(DEPTH)-1:0]      wr_addr,
   input  logic signed [DATA_WIDTH-1:0]  wr_data,
   input  logic [$clog2(DEPTH)-1:0]      rd_addr,
   input  logic                          rd_load,
   input  logic                          rd_clear,
   output logic signed [DATA_WIDTH-1:0]  rd_data
);

   logic signed [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Same-edge read sees the pre-write contents, so rd_addr == wr_addr yields the oldest sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rd_data <= '0;
      else if (rd_clear)
         rd_data <= '0;
      else if (rd_load)
         rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/multichannel_delay_line.sv
// rtl/multichannel_delay_line.sv - multi-channel programmable delay line; option MULTICHANNEL_DELAY_LINE_ZERO_FILL_EN
module multichannel_delay_line
   import package_settings::*;
#(
   parameter int DATA_WIDTH   = SIZE_DATA,
   parameter int NUM_CHANNELS = NUM_CHANNELS_DEFAULT,
   parameter int MAX_DELAY    = MAX_DELAY_DEFAULT,
   localparam int DELAY_WIDTH = $clog2(MAX_DELAY) + 1
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   input_data,
   input  logic                                 input_valid,
   input  logic                                 enable,
   input  logic [DELAY_WIDTH-1:0]               delay_sel,
   input  logic                                 delay_load,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   output_data,
   output logic                                 output_valid,
   output logic                                 fill_busy
);

   localparam int AW = $clog2(MAX_DELAY);
   localparam logic [DELAY_WIDTH-1:0] D_MAX = DELAY_WIDTH'(MAX_DELAY);
   localparam logic [DELAY_WIDTH-1:0] D_ONE = DELAY_WIDTH'(1);
`ifdef MULTICHANNEL_DELAY_LINE_ZERO_FILL_EN
   localparam bit ZERO_FILL = 1'b1;
`else
   localparam bit ZERO_FILL = 1'b0;
`endif

   delay_state_t           state, state_n;
   logic [DELAY_WIDTH-1:0] fill_cnt, cnt_n;
   logic [DELAY_WIDTH-1:0] d_reg, d_new, d_eff;
   logic [AW-1:0]          wr_ptr, rd_addr;
   logic                   emit, emit_zero;

   always_comb begin
      if (delay_sel == '0)
         d_new = D_ONE;
      else if (delay_sel > D_MAX)
         d_new = D_MAX;
      else
         d_new = delay_sel;
   end

   assign d_eff   = delay_load ? d_new : d_reg;
   assign rd_addr = wr_ptr - d_eff[AW-1:0];

   // A beat arriving with delay_load is the first fill beat under the new delay.
   always_comb begin
      state_n   = state;
      cnt_n     = fill_cnt;
      emit      = 1'b0;
      emit_zero = 1'b0;
      if (delay_load) begin
         cnt_n     = input_valid ? D_ONE : '0;
         state_n   = (input_valid && d_new == D_ONE) ? RUN : FILL;
         emit_zero = ZERO_FILL && input_valid;
      end else if (input_valid) begin
         case (state)
            FILL: begin
               cnt_n     = fill_cnt + D_ONE;
               emit_zero = ZERO_FILL;
               if (cnt_n >= d_reg) state_n = RUN;
            end
            RUN:     emit = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= FILL;
         fill_cnt     <= '0;
         d_reg        <= D_MAX;
         wr_ptr       <= '0;
         output_valid <= 1'b0;
      end else begin
         state        <= state_n;
         fill_cnt     <= cnt_n;
         if (delay_load) d_reg <= d_new;
         if (input_valid) wr_ptr <= wr_ptr + AW'(1);
         output_valid <= enable && (emit || emit_zero);
      end
   end

   assign fill_busy = (state == FILL);

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      delay_line_buffer #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (MAX_DELAY)
      ) u_buf (
         .clk      (clk),
         .reset    (reset),
         .wr_en    (input_valid),
         .wr_addr  (wr_ptr),
         .wr_data  (input_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .rd_addr  (rd_addr),
         .rd_load  (enable && emit),
         .rd_clear (!enable || emit_zero),
         .rd_data  (output_data[c*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: doc/multichannel_delay_line.md
Name: multichannel_delay_line

Overview:
- Parametrised multi-channel successor of the fixed single-channel shift-register delay.
- Delays NUM_CHANNELS signed sample streams by a runtime-programmable number of valid beats, D = 1..MAX_DELAY.
- Storage is a circular buffer. A fill state machine suppresses stale output after reset or a delay change.
- Sits between the sample front-end and the downstream DSP stages.

Parameters:
- DATA_WIDTH, default SIZE_DATA: bits per channel sample, signed.
- NUM_CHANNELS, default 4: number of parallel channels sharing one valid/pointer.
- MAX_DELAY, default 16: buffer depth in samples; must be a power of two, at least 2.
- DELAY_WIDTH (localparam), $clog2(MAX_DELAY)+1: width of delay_sel.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, asynchronous, active-low.
- input_data, input, NUM_CHANNELS*DATA_WIDTH: channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- input_valid, input, 1: one sample per channel accepted on this cycle (a "beat").
- enable, input, 1: output gate.
- delay_sel, input, DELAY_WIDTH: requested delay in beats.
- delay_load, input, 1: single-cycle strobe that latches delay_sel.
- output_data, output, NUM_CHANNELS*DATA_WIDTH: signed delayed samples, same packing as input_data.
- output_valid, output, 1: output_data holds a delayed sample this cycle.
- fill_busy, output, 1: high while the state machine is in FILL.

Behaviour:
- Reset values:
  - output_data = 0, output_valid = 0, fill_busy = 1.
  - Buffer contents = 0, wr_ptr = 0, fill_cnt = 0.
  - D = MAX_DELAY, state = FILL.
- Delay latch:
  - On delay_load, D <= clamp(delay_sel): 0 becomes 1; values above MAX_DELAY become MAX_DELAY.
  - Also on delay_load: fill_cnt <= 0, state <= FILL.
  - Buffer contents and wr_ptr are not disturbed.
- Write path, on every beat:
  - Each channel writes buf[c][wr_ptr].
  - wr_ptr increments modulo MAX_DELAY and wraps with no gap.
- Read path:
  - Read address = (wr_ptr - D) mod MAX_DELAY, read-before-write.
  - For D = MAX_DELAY the read address equals the write address, and the old contents are returned.
- Latency:
  - Output for beat n is sample n-D, registered and presented one clk after the beat.
  - Non-beat cycles: output_valid = 0; output_data holds its last value.
- States:
  - FILL: each beat increments fill_cnt with no output. When fill_cnt reaches D, the next state is RUN. That beat itself produces no output.
  - RUN: every beat produces output_valid = 1 on the next cycle.
- delay_load together with input_valid in the same cycle:
  - The beat is written and counts as fill_cnt = 1 under the new D.
  - If the new D equals 1, state goes to RUN immediately.
- enable:
  - When enable = 0 on the output-register cycle, output_data <= 0 and output_valid <= 0.
  - Writes and state progress continue.
  - When enable is re-asserted, output resumes with correctly delayed data and no refill.
- Arithmetic: pure storage; no width change or sign change.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); the first beat after deassertion starts FILL with D = MAX_DELAY.

Optional Feature:
- Macro: MULTICHANNEL_DELAY_LINE_ZERO_FILL_EN.
- Defined:
  - A FILL beat also produces output_valid = 1 with output_data = 0 (subject to enable).
  - The stream therefore appears pre-loaded with zeros, so the output beat count equals the input beat count.
  - fill_busy still reflects FILL.
- Undefined: FILL beats produce no output, as described above.

Decomposition:
- Package package_settings gains:
  - MAX_DELAY_DEFAULT and NUM_CHANNELS_DEFAULT constants.
  - typedef enum logic {FILL, RUN} delay_state_t.
  - typedef for the per-channel sample (logic signed [SIZE_DATA-1:0]).
- One sub-module, delay_line_buffer: a single-channel circular buffer with write enable, write pointer and read address, giving a registered read-before-write output. It is instantiated NUM_CHANNELS times in a generate loop.
- The pointer, clamp and FSM logic stay in the top module.

Test Plan:
- Reset, then 20 beats with ch0 = 1..20 and enable = 1 at default D = 16 -> no output for beats 1..16; beats 17..20 output 1..4 one cycle later; fill_busy falls after beat 16.
- delay_load with delay_sel = 3, then beats ch0 = 100..110, other channels = -(value) -> first output on the 4th beat equals 100 (ch0) and -100 (ch1..3); outputs stay consecutive afterwards.
- delay_sel = 0 and then 31 loaded -> effective D = 1 and D = 16 respectively; with D = 1 each output equals the previous beat; wraparound continues past 40 beats.
- In RUN with D = 4, input_valid toggled every other cycle and enable dropped for beats 10..12 -> output_valid tracks beats; outputs are 0 and invalid during the drop; beat 13 outputs sample 9 without refill.
- delay_load in the same cycle as a beat with delay_sel = 2, then reset pulsed mid-stream -> the load-cycle beat counts as fill 1 and output starts at beat 3; after reset all outputs are 0, fill_busy = 1 and D = 16.
- ZERO_FILL_EN build, D = 5, beats 1..8 -> outputs 0,0,0,0,0,1,2,3 with output_valid on every beat.
